// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the cycle sequencer
// Purpose: 3-bit sequencer state enum and 2-bit instruction class enum.
// Ports: none (package).
package seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_PCUPDATE  = 3'd5,
    ST_HALT      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } class_t;

  // Wait counter width; covers the full MEM_TIMEOUT range of 2..255.
  localparam int WAIT_W = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - memory wait counter with timeout compare
// Purpose: counts cycles spent waiting on mem_ready; flags the last legal wait cycle.
// Ports:
//   clk     - clock
//   reset   - synchronous active-low reset
//   clear   - zero the counter (takes priority over inc)
//   inc     - advance the counter by one
//   expired - counter has reached MEM_TIMEOUT-1
module seq_wait_timer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/cycle_sequencer.sv
// rtl/cycle_sequencer.sv - multi-cycle instruction sequencer control FSM
// Purpose: steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK/PCUPDATE with HALT and
//   timeout ERROR terminal states. Optional macro SEQ_INSTRET_EN enables the
//   retired-instruction counter; otherwise instret is tied to 0.
// Ports:
//   clk, reset             - clock, synchronous active-low reset
//   mem_ready              - memory access complete this cycle
//   instr_class, is_halt   - decode inputs, sampled in DECODE only
//   mem_req, mem_we        - memory request / write strobe
//   IR_load, alu_en        - instruction register load, ALU enable
//   reg_we, PC_en          - register write, PC update
//   halted, timeout_err    - terminal state flags
//   state_o                - current state encoding
//   instret                - retired instruction count
module cycle_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_ready,
  input  logic [1:0]       instr_class,
  input  logic             is_halt,
  output logic             mem_req,
  output logic             mem_we,
  output logic             IR_load,
  output logic             alu_en,
  output logic             reg_we,
  output logic             PC_en,
  output logic             halted,
  output logic             timeout_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_t state_q, state_d;
  class_t class_q, class_d;
  logic   wait_active;
  logic   expired;
  logic   timer_clear;
  logic   timer_inc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      class_q <= CLS_ALU;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    IR_load     = 1'b0;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    PC_en       = 1'b0;
    halted      = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IR_load = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        class_d = class_t'(instr_class);
        state_d = is_halt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        alu_en = 1'b1;
        case (class_q)
          CLS_ALU:    state_d = ST_WRITEBACK;
          CLS_BRANCH: state_d = ST_PCUPDATE;
          default:    state_d = ST_MEM;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (class_q == CLS_STORE);
        // mem_ready wins over a simultaneous timeout
        if (mem_ready) begin
          state_d = (class_q == CLS_STORE) ? ST_PCUPDATE : ST_WRITEBACK;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITEBACK: begin
        reg_we  = 1'b1;
        state_d = ST_PCUPDATE;
      end
      ST_PCUPDATE: begin
        PC_en   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      ST_ERROR: begin
        timeout_err = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Counter restarts whenever a wait state is entered, so it only runs while
  // the FSM sits in the same FETCH or MEM visit.
  assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_clear = !(wait_active && (state_d == state_q));
  assign timer_inc   = wait_active && !mem_ready;

  seq_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .inc    (timer_inc),
    .expired(expired)
  );

  assign state_o = state_q;

`ifdef SEQ_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      instret_q <= '0;
    end else if (state_q == ST_PCUPDATE) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb/tb_cycle_sequencer.sv - directed self-checking bench for cycle_sequencer
module tb_cycle_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_ready;
  logic [1:0] instr_class;
  logic       is_halt;
  logic       mem_req, mem_we, IR_load, alu_en, reg_we, PC_en, halted, timeout_err;
  logic [2:0] state_o;
  logic [3:0] instret;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;

`ifdef SEQ_INSTRET_EN
  localparam bit RET_ON = 1'b1;
`else
  localparam bit RET_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  cycle_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .instr_class(instr_class),
    .is_halt    (is_halt),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .IR_load    (IR_load),
    .alu_en     (alu_en),
    .reg_we     (reg_we),
    .PC_en      (PC_en),
    .halted     (halted),
    .timeout_err(timeout_err),
    .state_o    (state_o),
    .instret    (instret)
  );

  function automatic logic [3:0] ret_val(input int n);
    ret_val = RET_ON ? 4'(n % 16) : 4'd0;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [9:0] got;
    reset = 1'b0; mem_ready = 1'b0; instr_class = 2'd0; is_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {mem_req, mem_we, IR_load, alu_en, reg_we, PC_en, halted, timeout_err, 2'b00};
    checks++;
    if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++;
    if (got !== 10'b1000000000) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", got, 10'b1000000000); end
    checks++;
    if (instret !== 4'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || mem_req !== 1'b1) begin
      failures++; $display("FAIL post_reset got_state=%0d got_req=%b exp=0/1", state_o, mem_req);
    end
    exp_ret = 0;
  endtask

  task automatic test_alu;
    int exp_st[5] = '{0, 1, 2, 4, 5};
    int n_ir = 0, n_alu = 0, n_we = 0, n_pc = 0;
    instr_class = 2'd0; is_halt = 1'b0; mem_ready = 1'b1;
    checks++;
    if (instret !== ret_val(exp_ret)) begin failures++; $display("FAIL alu_instret_pre got=%0d exp=%0d", instret, ret_val(exp_ret)); end
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_o !== 3'(exp_st[i])) begin failures++; $display("FAIL alu_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]); end
      n_ir += int'(IR_load); n_alu += int'(alu_en); n_we += int'(reg_we); n_pc += int'(PC_en);
      tick;
    end
    exp_ret++;
    checks++;
    if (n_ir != 1 || n_alu != 1 || n_we != 1 || n_pc != 1) begin
      failures++; $display("FAIL alu_pulses got=%0d/%0d/%0d/%0d exp=1/1/1/1", n_ir, n_alu, n_we, n_pc);
    end
    checks++;
    if (state_o !== 3'd0) begin failures++; $display("FAIL alu_end_state got=%0d exp=0", state_o); end
    checks++;
    if (instret !== ret_val(exp_ret)) begin failures++; $display("FAIL alu_instret got=%0d exp=%0d", instret, ret_val(exp_ret)); end
  endtask

  task automatic test_load_delayed;
    int exp_st[11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 5};
    bit rdy[11]    = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int n_we = 0, n_fetch = 0, n_mem = 0;
    instr_class = 2'd1; is_halt = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state_o !== 3'(exp_st[i])) begin failures++; $display("FAIL load_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]); end
      if (state_o == 3'd3) begin
        n_mem++;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
          failures++; $display("FAIL load_mem_strobes[%0d] got=%b%b exp=10", i, mem_req, mem_we);
        end
      end
      if (state_o == 3'd0) n_fetch++;
      n_we += int'(reg_we);
      tick;
    end
    exp_ret++;
    checks++;
    if (n_fetch != 4 || n_mem != 3 || n_we != 1) begin
      failures++; $display("FAIL load_counts got=%0d/%0d/%0d exp=4/3/1", n_fetch, n_mem, n_we);
    end
    checks++;
    if (state_o !== 3'd0 || instret !== ret_val(exp_ret)) begin
      failures++; $display("FAIL load_end got_state=%0d got_ret=%0d exp=0/%0d", state_o, instret, ret_val(exp_ret));
    end
  endtask

  task automatic test_store_edge;
    int exp_st[8] = '{0, 1, 2, 3, 3, 3, 3, 5};
    bit rdy[8]    = '{1, 0, 0, 0, 0, 0, 1, 0};
    instr_class = 2'd2; is_halt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state_o !== 3'(exp_st[i]) || timeout_err !== 1'b0) begin
        failures++; $display("FAIL store_state[%0d] got=%0d err=%b exp=%0d err=0", i, state_o, timeout_err, exp_st[i]);
      end
      if (state_o == 3'd3) begin
        checks++;
        if (mem_we !== 1'b1 || mem_req !== 1'b1) begin
          failures++; $display("FAIL store_mem_we[%0d] got=%b%b exp=11", i, mem_req, mem_we);
        end
      end
      tick;
    end
    exp_ret++;
    checks++;
    if (state_o !== 3'd0 || instret !== ret_val(exp_ret)) begin
      failures++; $display("FAIL store_end got_state=%0d got_ret=%0d exp=0/%0d", state_o, instret, ret_val(exp_ret));
    end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b0; instr_class = 2'd0; is_halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state_o !== 3'd0) begin failures++; $display("FAIL timeout_fetch[%0d] got=%0d exp=0", i, state_o); end
      tick;
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state_o !== 3'd7 || timeout_err !== 1'b1 || mem_req !== 1'b0 || IR_load !== 1'b0 || halted !== 1'b0) begin
        failures++; $display("FAIL timeout_hold[%0d] got_state=%0d err=%b req=%b ir=%b exp=7/1/0/0", i, state_o, timeout_err, mem_req, IR_load);
      end
      tick;
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    exp_ret = 0;
    checks++;
    if (state_o !== 3'd0 || timeout_err !== 1'b0 || mem_req !== 1'b1 || instret !== 4'd0) begin
      failures++; $display("FAIL timeout_reset got_state=%0d err=%b req=%b ret=%0d exp=0/0/1/0", state_o, timeout_err, mem_req, instret);
    end
    tick;
  endtask

  task automatic test_halt;
    mem_ready = 1'b1; instr_class = 2'd0; is_halt = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || IR_load !== 1'b1) begin failures++; $display("FAIL halt_fetch got=%0d ir=%b exp=0/1", state_o, IR_load); end
    tick;
    is_halt = 1'b1; instr_class = 2'd3;
    #1;
    checks++;
    if (state_o !== 3'd1) begin failures++; $display("FAIL halt_decode got=%0d exp=1", state_o); end
    tick;
    for (int i = 0; i < 4; i++) begin
      is_halt = i[0]; instr_class = 2'(i); mem_ready = ~i[0];
      #1;
      checks++;
      if (state_o !== 3'd6 || halted !== 1'b1 || PC_en !== 1'b0 || mem_req !== 1'b0 || alu_en !== 1'b0) begin
        failures++; $display("FAIL halt_hold[%0d] got_state=%0d halted=%b pc=%b req=%b exp=6/1/0/0", i, state_o, halted, PC_en, mem_req);
      end
      tick;
    end
    checks++;
    if (instret !== ret_val(exp_ret)) begin failures++; $display("FAIL halt_instret got=%0d exp=%0d", instret, ret_val(exp_ret)); end
    is_halt = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    exp_ret = 0;
    checks++;
    if (state_o !== 3'd0 || halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%0d halted=%b exp=0/0", state_o, halted); end
    tick;
  endtask

  task automatic test_branch_wrap;
    int exp_st[4] = '{0, 1, 2, 5};
    mem_ready = 1'b1; instr_class = 2'd3; is_halt = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) begin
        #1;
        checks++;
        if (state_o !== 3'(exp_st[j])) begin failures++; $display("FAIL branch_state[%0d.%0d] got=%0d exp=%0d", k, j, state_o, exp_st[j]); end
        tick;
      end
      exp_ret++;
      checks++;
      if (instret !== ret_val(exp_ret)) begin failures++; $display("FAIL branch_instret[%0d] got=%0d exp=%0d", k, instret, ret_val(exp_ret)); end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_delayed;
    test_store_edge;
    test_timeout;
    test_halt;
    test_branch_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
